tick_timer_ctrl: RTL and testbench



---
 rtl/tick_timer_ctrl.sv | 156 +++++++++++++++
 tb/tb_tick_timer_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_ctrl.sv
// Programmable interval timer: mod-PRESC prescaler feeding a period counter, one-shot or periodic.
// Optional pause input is compiled in when TICK_TIMER_PAUSE_EN is defined.
module tick_timer_ctrl #(
  parameter int PRESC = 10,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
`ifdef TICK_TIMER_PAUSE_EN
  input  logic         pause,
`endif
  input  logic [W-1:0] period,
  input  logic         mode,
  output logic         busy,
  output logic         tick,
  output logic         expire,
  output logic         err,
  output logic [W-1:0] remain
);

  localparam int            PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [W-1:0]  REMAIN_ONE = W'(1'b1);
  localparam logic [W-1:0]  REMAIN_ZERO = {W{1'b0}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  remain_q, remain_d;
  logic [W-1:0]  period_q, period_d;
  logic          mode_q, mode_d;
  logic          expire_q, expire_d;
  logic          err_q, err_d;
  logic          pause_s;
  logic          tick_s;

`ifdef TICK_TIMER_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  function automatic logic [PW-1:0] presc_next(input logic [PW-1:0] p);
    if (p == PRESC_LAST) begin
      return PRESC_ZERO;
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Tick decode: last prescaler count of an unpaused RUN cycle
  always_comb begin
    if ((state_q == S_RUN) && !pause_s && (presc_q == PRESC_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    period_d = period_q;
    mode_d   = mode_q;
    expire_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d  = PRESC_ZERO;
        remain_d = REMAIN_ZERO;
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          if (period == REMAIN_ZERO) begin
            err_d = 1'b1;
          end else begin
            period_d = period;
            mode_d   = mode;
            remain_d = period;
            state_d  = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // stop outranks any tick landing in the same cycle
        if (stop) begin
          state_d  = S_IDLE;
          presc_d  = PRESC_ZERO;
          remain_d = REMAIN_ZERO;
        end else if (pause_s) begin
          presc_d  = presc_q;
          remain_d = remain_q;
        end else begin
          presc_d = presc_next(presc_q);
          if (!tick_s) begin
            remain_d = remain_q;
          end else if (remain_q > REMAIN_ONE) begin
            remain_d = remain_q - REMAIN_ONE;
          end else begin
            expire_d = 1'b1;
            if (mode_q) begin
              remain_d = period_q;
            end else begin
              remain_d = REMAIN_ZERO;
              state_d  = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        presc_d  = PRESC_ZERO;
        remain_d = REMAIN_ZERO;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= PRESC_ZERO;
      remain_q <= REMAIN_ZERO;
      period_q <= REMAIN_ZERO;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign tick   = tick_s;
  assign expire = expire_q;
  assign err    = err_q;
  assign remain = remain_q;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Scoreboard bench for tick_timer_ctrl (PRESC=4, W=8): directed vectors, expire/err events checked by a monitor.
module tb_tick_timer_ctrl;

  localparam int PRESC = 4;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] period = 8'd0;
`ifdef TICK_TIMER_PAUSE_EN
  logic         pause = 1'b0;
`endif
  logic         busy, tick, expire, err;
  logic [W-1:0] remain;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int c0 = 0;

  typedef struct {
    int at;
    int is_err;
    int rem;
    int bsy;
  } ev_t;
  ev_t sb[$];

  tick_timer_ctrl #(.PRESC(PRESC), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
`ifdef TICK_TIMER_PAUSE_EN
    .pause  (pause),
`endif
    .period (period),
    .mode   (mode),
    .busy   (busy),
    .tick   (tick),
    .expire (expire),
    .err    (err),
    .remain (remain)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(input int at, input int is_err, input int rem, input int bsy);
    ev_t e;
    e.at = at;
    e.is_err = is_err;
    e.rem = rem;
    e.bsy = bsy;
    sb.push_back(e);
  endfunction

  // Monitor: every expire/err strobe must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (expire || err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got expire=%0b err=%0b expected none (cycle %0d)", expire, err, cyc);
      end else begin
        e = sb.pop_front();
        chk("ev_cycle", cyc, e.at);
        chk("ev_err", int'(err), e.is_err);
        chk("ev_expire", int'(expire), 1 - e.is_err);
        chk("ev_remain", int'(remain), e.rem);
        chk("ev_busy", int'(busy), e.bsy);
      end
    end
  end

  task automatic begin_test();
    @(posedge clk);
    #1;
    c0 = cyc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("por_busy", int'(busy), 0);
      chk("por_remain", int'(remain), 0);
      chk("por_tick", int'(tick), 0);
      chk("por_expire", int'(expire), 0);
      chk("por_err", int'(err), 0);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_busy", int'(busy), 0);
    chk("rel_remain", int'(remain), 0);

    // One-shot, period 3
    begin_test();
    start = 1'b1; period = 8'd3; mode = 1'b0;
    push_ev(c0 + 13, 0, 0, 0);
    for (int rel = 0; rel <= 14; rel++) begin
      if (rel > 0) next_cycle();
      if (rel == 1) start = 1'b0;
      @(negedge clk);
      chk("os_tick", int'(tick), int'(rel == 4 || rel == 8 || rel == 12));
      chk("os_busy", int'(busy), int'(rel >= 1 && rel <= 12));
      chk("os_remain", int'(remain),
          (rel >= 1 && rel <= 4) ? 3 : (rel >= 5 && rel <= 8) ? 2 : (rel >= 9 && rel <= 12) ? 1 : 0);
    end

    // Periodic, period 2, stopped in cycle 26
    begin_test();
    start = 1'b1; period = 8'd2; mode = 1'b1;
    push_ev(c0 + 9, 0, 2, 1);
    push_ev(c0 + 17, 0, 2, 1);
    push_ev(c0 + 25, 0, 2, 1);
    for (int rel = 0; rel <= 28; rel++) begin
      if (rel > 0) next_cycle();
      if (rel == 1) start = 1'b0;
      if (rel == 26) stop = 1'b1;
      if (rel == 27) stop = 1'b0;
      @(negedge clk);
      chk("per_busy", int'(busy), int'(rel >= 1 && rel <= 26));
      chk("per_tick", int'(tick), int'(rel >= 4 && rel <= 26 && (rel % 4) == 0));
      chk("per_remain", int'(remain),
          (rel >= 1 && rel <= 26) ? ((((rel - 1) / 4) % 2 == 0) ? 2 : 1) : 0);
    end

    // One-shot period 5 stopped in cycle 6, restarted with period 2 in cycle 7
    begin_test();
    start = 1'b1; period = 8'd5; mode = 1'b0;
    push_ev(c0 + 16, 0, 0, 0);
    for (int rel = 0; rel <= 22; rel++) begin
      if (rel > 0) next_cycle();
      if (rel == 1) start = 1'b0;
      if (rel == 6) stop = 1'b1;
      if (rel == 7) begin
        stop = 1'b0; start = 1'b1; period = 8'd2;
      end
      if (rel == 8) start = 1'b0;
      @(negedge clk);
      chk("stp_busy", int'(busy), int'((rel >= 1 && rel <= 6) || (rel >= 8 && rel <= 15)));
      chk("stp_tick", int'(tick), int'(rel == 4 || rel == 11 || rel == 15));
      chk("stp_remain", int'(remain),
          (rel >= 1 && rel <= 4) ? 5 : (rel >= 5 && rel <= 6) ? 4 :
          (rel >= 8 && rel <= 11) ? 2 : (rel >= 12 && rel <= 15) ? 1 : 0);
    end

    // Zero period is rejected with a single err strobe
    begin_test();
    start = 1'b1; period = 8'd0; mode = 1'b0;
    push_ev(c0 + 1, 1, 0, 0);
    for (int rel = 0; rel <= 4; rel++) begin
      if (rel > 0) next_cycle();
      if (rel == 1) start = 1'b0;
      @(negedge clk);
      chk("zp_err", int'(err), int'(rel == 1));
      chk("zp_busy", int'(busy), 0);
      chk("zp_remain", int'(remain), 0);
    end

    // start together with stop does nothing
    begin_test();
    start = 1'b1; stop = 1'b1; period = 8'd7;
    for (int rel = 0; rel <= 5; rel++) begin
      if (rel > 0) next_cycle();
      if (rel == 1) begin
        start = 1'b0; stop = 1'b0;
      end
      @(negedge clk);
      chk("ss_busy", int'(busy), 0);
      chk("ss_remain", int'(remain), 0);
      chk("ss_err", int'(err), 0);
    end

    // Asynchronous reset mid-run, held three cycles; no expire afterwards
    begin_test();
    start = 1'b1; period = 8'd5; mode = 1'b1;
    for (int rel = 0; rel <= 26; rel++) begin
      if (rel > 0) next_cycle();
      if (rel == 1) start = 1'b0;
      if (rel == 3) rst = 1'b1;
      if (rel == 6) rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), int'(rel == 1 || rel == 2));
      chk("rst_remain", int'(remain), (rel == 1 || rel == 2) ? 5 : 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_expire", int'(expire), 0);
      chk("rst_err", int'(err), 0);
    end

`ifdef TICK_TIMER_PAUSE_EN
    // Pause during cycles 3-7 shifts tick to 9 and expire to 14
    begin_test();
    start = 1'b1; period = 8'd2; mode = 1'b0;
    push_ev(c0 + 14, 0, 0, 0);
    for (int rel = 0; rel <= 16; rel++) begin
      if (rel > 0) next_cycle();
      if (rel == 1) start = 1'b0;
      if (rel == 3) pause = 1'b1;
      if (rel == 8) pause = 1'b0;
      @(negedge clk);
      chk("pz_tick", int'(tick), int'(rel == 9 || rel == 13));
      chk("pz_busy", int'(busy), int'(rel >= 1 && rel <= 13));
      chk("pz_remain", int'(remain), (rel >= 1 && rel <= 9) ? 2 : (rel >= 10 && rel <= 13) ? 1 : 0);
    end
`endif

    next_cycle();
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
